// File: rtl/i2s_xmtr_output_cntlr.sv
// I2S transmitter output controller.
// Holds one stereo pair, divides clk down to sck, and shifts each frame out on
// sd MSB-first (left then right) with the standard one-bit ws/data delay.
module i2s_xmtr_output_cntlr #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_ready,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * DATA_WIDTH;
  localparam int SLOT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    sck_q, sck_d;
  logic                    ws_q, ws_d;
  logic                    sd_q, sd_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    ready_q;
  logic                    underrun_q, underrun_d;
  logic                    tick;
  logic                    load;

  // ws is high from the last left slot through the second-to-last right slot,
  // giving the one-slot lead of ws over data.
  function automatic logic ws_for_slot(input int k);
    return (k >= DATA_WIDTH - 1) && (k <= FRAME_BITS - 2);
  endfunction

  // State, divider, slot, serial outputs and holding register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      slot_q      <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      slot_q      <= slot_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state: sck division, slot sequencing, frame load and handshake.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    slot_d      = slot_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    tick        = (div_q == DIV_MAX);

    case (state_q)
      IDLE: begin
        div_d  = '0;
        slot_d = '0;
        sck_d  = 1'b0;
        ws_d   = 1'b0;
        sd_d   = 1'b0;
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          div_d = '0;
          sck_d = ~sck_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        // A falling sck toggle closes the current slot.
        if (tick && sck_q) begin
          if (slot_q != LAST_SLOT) begin
            slot_d  = slot_q + 1'b1;
            shift_d = shift_q << 1;
            sd_d    = shift_q[FRAME_BITS-2];
            ws_d    = ws_for_slot(int'(slot_q) + 1);
          end else if (enable) begin
            slot_d = '0;
            load   = 1'b1;
          end else begin
            state_d = IDLE;
            slot_d  = '0;
            ws_d    = 1'b0;
            sd_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load samples the holding flag before this clk's handshake, so a pair
    // offered on the load edge lands in holding for the following frame.
    if (load) begin
      shift_d    = hold_full_q ? hold_q : '0;
      sd_d       = shift_d[FRAME_BITS-1];
      ws_d       = ws_for_slot(0);
      underrun_d = !hold_full_q;
      if (hold_full_q) begin
        hold_full_d = 1'b0;
      end
    end

    if (sample_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = {left_data, right_data};
    end
  end

  assign sample_ready = ready_q;
  assign sck          = sck_q;
  assign ws           = ws_q;
  assign sd           = sd_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_xmtr_output_cntlr.sv
// Self-checking bench for i2s_xmtr_output_cntlr: every clk the outputs are
// compared with a frame-timing model computed from the cycle count since RUN.
module tb_i2s_xmtr_output_cntlr;

  localparam int DW        = 16;
  localparam int CD        = 2;
  localparam int FB        = 2 * DW;
  localparam int SLOT_CLK  = 2 * CD;
  localparam int FRAME_CLK = FB * SLOT_CLK;

  logic          clk;
  logic          n_rst;
  logic          enable;
  logic          sample_valid;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          sample_ready;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          underrun;

  i2s_xmtr_output_cntlr #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_ready (sample_ready),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_run   = 1'b0;
  int          m_c     = 0;
  logic [31:0] m_frame = '0;
  logic [31:0] m_hold  = '0;
  bit          m_hfull = 1'b0;
  bit          m_und   = 1'b0;
  bit          m_acc   = 1'b0;

  // Monitor state
  logic [31:0] cap      = '0;
  logic        prev_sck = 1'b0;
  int          und_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_load();
    if (m_hfull) begin
      m_frame = m_hold;
      m_hfull = 1'b0;
    end else begin
      m_frame = '0;
      m_und   = 1'b1;
    end
  endtask

  // Applies one posedge worth of the transmitter rules to the model.
  task automatic model_edge();
    bit was_full;
    was_full = m_hfull;
    m_und    = 1'b0;
    m_acc    = 1'b0;
    if (!n_rst) begin
      m_run   = 1'b0;
      m_hfull = 1'b0;
      return;
    end
    if (!m_run) begin
      if (enable) begin
        m_run = 1'b1;
        m_c   = 0;
        model_load();
      end
    end else begin
      m_c++;
      if (m_c == FRAME_CLK) begin
        if (enable) begin
          m_c = 0;
          model_load();
        end else begin
          m_run = 1'b0;
        end
      end
    end
    if (sample_valid && !was_full) begin
      m_hfull = 1'b1;
      m_hold  = {left_data, right_data};
      m_acc   = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    int   slot;
    logic e_sck, e_ws, e_sd;
    e_sck = 1'b0;
    e_ws  = 1'b0;
    e_sd  = 1'b0;
    if (m_run) begin
      slot  = m_c / SLOT_CLK;
      e_sck = ((m_c / CD) % 2) == 1;
      e_sd  = m_frame[FB-1-slot];
      e_ws  = (slot >= DW - 1) && (slot <= FB - 2);
    end
    check("sck", 32'(sck), 32'(e_sck));
    check("ws", 32'(ws), 32'(e_ws));
    check("sd", 32'(sd), 32'(e_sd));
    check("sample_ready", 32'(sample_ready), 32'(!m_hfull));
    check("underrun", 32'(underrun), 32'(m_und));
    if (sck && !prev_sck) cap = {cap[30:0], sd};
    prev_sck = sck;
    if (underrun) und_seen++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send_pair(input logic [31:0] p);
    bit done;
    done         = 1'b0;
    left_data    = p[31:16];
    right_data   = p[15:0];
    sample_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLK && !done; i++) begin
      cycle();
      done = m_acc;
    end
    sample_valid = 1'b0;
    check("accept_bound", 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] p;

    n_rst        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    left_data    = '0;
    right_data   = '0;
    #1 n_rst = 1'b0;
    #1;
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    repeat (3) cycle();
    n_rst = 1'b1;

    // Idle with enable low
    repeat (200) cycle();

    // Single frame
    send_pair(32'hA5C3_0FF1);
    cap    = '0;
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    repeat (FRAME_CLK + 8) cycle();
    check("single_frame_data", cap, 32'hA5C3_0FF1);

    // Continuous stream of four pairs
    und_seen = 0;
    send_pair($urandom);
    enable = 1'b1;
    for (int i = 1; i < 4; i++) begin
      p = $urandom;
      send_pair(p);
    end
    repeat (FRAME_CLK + 10) cycle();
    enable = 1'b0;
    repeat (FRAME_CLK + 8) cycle();
    check("stream_last_frame", cap, p);
    check("stream_underruns", und_seen, 0);

    // Underrun: three empty frames
    und_seen = 0;
    enable   = 1'b1;
    repeat (300) cycle();
    enable = 1'b0;
    repeat (FRAME_CLK) cycle();
    check("underrun_count", und_seen, 3);

    // Pair offered on the load edge with holding empty
    und_seen     = 0;
    p            = $urandom;
    left_data    = p[31:16];
    right_data   = p[15:0];
    sample_valid = 1'b1;
    enable       = 1'b1;
    cycle();
    sample_valid = 1'b0;
    check("same_cycle_underrun", und_seen, 1);
    repeat (FRAME_CLK + 10) cycle();
    enable = 1'b0;
    repeat (FRAME_CLK) cycle();
    check("same_cycle_next_frame", cap, p);

    // Async reset at slot 10, then a clean restart
    send_pair($urandom);
    enable = 1'b1;
    repeat (10 * SLOT_CLK + 1) cycle();
    #1 n_rst = 1'b0;
    #1;
    check("mid_rst_sck", 32'(sck), 32'd0);
    check("mid_rst_ws", 32'(ws), 32'd0);
    check("mid_rst_sd", 32'(sd), 32'd0);
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    enable = 1'b0;
    repeat (3) cycle();
    n_rst = 1'b1;
    p = $urandom;
    send_pair(p);
    enable = 1'b1;
    cycle();
    enable = 1'b0;
    repeat (FRAME_CLK + 8) cycle();
    check("restart_frame", cap, p);

    // Randomised enable and sample traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) enable = ~enable;
      sample_valid = ($urandom_range(3) == 0);
      left_data    = 16'($urandom);
      right_data   = 16'($urandom);
      cycle();
    end
    enable       = 1'b0;
    sample_valid = 1'b0;
    repeat (FRAME_CLK + 8) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_xmtr_output_cntlr.md
# i2s_xmtr_output_cntlr

I2S transmitter output controller: the transmit-side counterpart of the I2S receiver path. It accepts stereo sample pairs over a valid/ready handshake into a one-deep holding register. It generates the serial bit clock (sck) and word select (ws) by dividing clk, and shifts each pair out on sd MSB-first, left channel then right, using standard I2S one-bit data delay. It sits between the audio sample source (FIFO/DSP) and the chip's I2S output pins.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel sample; frame = 2*DATA_WIDTH sck periods
- CLK_DIV, 4, clk cycles per sck half-period (>= 1); sck period = 2*CLK_DIV clk

Ports:
- clk  input  1  system clock; all logic on posedge clk
- n_rst  input  1  reset, asynchronous, active-low
- enable  input  1  start/continue transmission; deassert stops at next frame boundary
- sample_valid  input  1  left_data/right_data hold a valid pair
- left_data  input  DATA_WIDTH  left-channel sample, two's complement
- right_data  input  DATA_WIDTH  right-channel sample, two's complement
- sample_ready  output  1  holding register empty; pair accepted when sample_valid & sample_ready at posedge
- sck  output  1  I2S serial bit clock
- ws  output  1  word select: 0 = left, 1 = right (leads data by one bit slot)
- sd  output  1  serial data, changes only when sck falls
- underrun  output  1  one-clk pulse: frame started with holding register empty

## Operation
- Reset values: sck 0, ws 0, sd 0, sample_ready 1, underrun 0; state IDLE; holding empty; div counter 0; slot counter 0.
- States: IDLE, RUN.
  - IDLE: sck/ws/sd held 0. If enable = 1 -> RUN, perform frame load, slot = 0.
  - RUN: div counter counts 0..CLK_DIV-1; at terminal count sck toggles and counter returns to 0.
  - A falling sck toggle ends the current slot. If slot < 2*DATA_WIDTH-1, slot increments. If slot = 2*DATA_WIDTH-1 and enable = 1, slot wraps to 0 with a frame load. If slot = 2*DATA_WIDTH-1 and enable = 0, the block goes to IDLE.
- Frame load:
  - If the holding register is full, shift register = {left, right} and holding is marked empty.
  - If the holding register is empty, shift register = 0 and underrun pulses for that one clk.
- Slot k output, registered at the start of the slot:
  - sd = shift[2*DATA_WIDTH-1-k]
  - ws = 1 iff DATA_WIDTH-1 <= k <= 2*DATA_WIDTH-2
- Holding register: sample_ready = !hold_full, driven directly from a register. A handshake sets hold_full.
- Load and handshake in the same clk (holding empty at load): the load sees empty, so zeros are sent and underrun pulses. The handshake data fills holding for the next frame.
- A load with holding full and no handshake leaves holding empty. While holding is full, sample_ready = 0, so no simultaneous fill is possible.
- Data is sent verbatim; no width conversion or sign handling.

## Timing
- Enable latency: enable high in IDLE at edge N -> sd = left MSB, ws = 0, sck = 0 after edge N.
- First sck rise occurs CLK_DIV clks after RUN entry. Each slot lasts exactly 2*CLK_DIV clks; a frame lasts 2*DATA_WIDTH*2*CLK_DIV clks.
- sd and ws change only in the same clk that sck goes 1->0, or on RUN entry. They are stable across each rising sck edge, where the receiver samples.
- Frames are back-to-back with no gap while enable = 1.
- A pair accepted at any time before a frame's load edge is transmitted in that frame.
- Deassertion of enable mid-frame has no effect until the final slot ends. The final slot is full length, then the block is in IDLE and outputs are 0.
- Reset mid-frame: all outputs return to reset values immediately (async). The partial frame and holding contents are discarded.

## Test plan
(DATA_WIDTH=16, CLK_DIV=2, frame = 128 clk)
- Reset idle: reset, enable=0 for 200 clk -> sck=ws=sd=0, sample_ready=1, underrun=0 throughout.
- Single frame: load left=16'hA5C3, right=16'h0FF1, then enable=1 for one clk -> serial data sampled on 32 sck rises = A5C3 then 0FF1 MSB-first. ws = 0 for slots 0..14 and 31, 1 for slots 15..30. After 128 clk: IDLE, all outputs 0.
- Continuous stream: enable held high, 4 pairs supplied with valid held high -> 4 back-to-back frames decode correctly with no underrun. sample_ready falls on accept and rises on each frame load.
- Underrun: enable=1 with no samples -> sd=0 for the whole frame. underrun pulses once per frame at each load edge (every 128 clk), never elsewhere.
- Same-cycle load and handshake: present a pair exactly at a load edge with holding empty -> current frame is zeros with underrun=1. The next frame carries the pair.
- Async reset mid-frame at slot 10: outputs are 0 immediately and sample_ready=1. Re-enable -> a clean frame starts at slot 0.
